// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the MEM-stage load path:
//   - LoadSize encodings (byte / halfword / word)
//   - FSM state encoding for mem_read_ctrl (IDLE, WAIT, DONE)
//   - is_aligned(): alignment rule for a load of a given size
// -----------------------------------------------------------------------------
package mem_pkg;

  // LoadSize encodings; 2'b11 also behaves as a word load.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Controller state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // A byte is always aligned, a halfword needs addr[0]=0,
  // a word needs addr[1:0]=00.
  function automatic logic is_aligned(input logic [1:0] size,
                                      input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~addr_lo[0];
      default: ok = (addr_lo == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_read_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_read_ctrl_if
// Bundles the pipeline-side load controls and the RAM read port seen by
// mem_read_ctrl.
//   Pipeline -> ctrl : MemRead, MemAddr, LoadSize, LoadUnsigned
//   ctrl -> pipeline : Stall, LoadData, LoadValid, MisalignErr
//   ctrl -> RAM      : mem_en, mem_addr (word address)
//   RAM -> ctrl      : mem_rdata
// Modports: slave = the controller, master = its environment.
// -----------------------------------------------------------------------------
interface mem_read_ctrl_if #(
  parameter int AddrBits = 32,
  parameter int DataBits = 32
);

  logic                MemRead;
  logic [AddrBits-1:0] MemAddr;
  logic [1:0]          LoadSize;
  logic                LoadUnsigned;
  logic                mem_en;
  logic [AddrBits-3:0] mem_addr;
  logic [DataBits-1:0] mem_rdata;
  logic                Stall;
  logic [DataBits-1:0] LoadData;
  logic                LoadValid;
  logic                MisalignErr;

  modport slave (
    input  MemRead, MemAddr, LoadSize, LoadUnsigned, mem_rdata,
    output mem_en, mem_addr, Stall, LoadData, LoadValid, MisalignErr
  );

  modport master (
    output MemRead, MemAddr, LoadSize, LoadUnsigned, mem_rdata,
    input  mem_en, mem_addr, Stall, LoadData, LoadValid, MisalignErr
  );

endinterface

// File: rtl/load_align_ext.sv
// -----------------------------------------------------------------------------
// load_align_ext
// Purely combinational lane select and sign/zero extension of a 32-bit RAM
// word (little-endian byte lanes).
//   i_rdata    : RAM word
//   i_offset   : byte offset of the load within the word
//   i_size     : SZ_BYTE / SZ_HALF / word
//   i_unsigned : 1 zero-extends, 0 sign-extends byte/half
//   o_data     : aligned, extended result
// -----------------------------------------------------------------------------
module load_align_ext
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_byte_ext;
  logic        w_half_ext;

  // Halfword lane uses only offset[1]; offset[0] is guaranteed 0 upstream.
  assign w_byte     = i_rdata[{i_offset, 3'b000} +: 8];
  assign w_half     = i_rdata[{i_offset[1], 4'b0000} +: 16];
  assign w_byte_ext = ~i_unsigned & w_byte[7];
  assign w_half_ext = ~i_unsigned & w_half[15];

  always_comb begin
    // NOTE: default assignment first so no path leaves o_data unassigned,
    // which would otherwise infer a latch.
    o_data = i_rdata;
    case (i_size)
      SZ_BYTE: o_data = {{24{w_byte_ext}}, w_byte};
      SZ_HALF: o_data = {{16{w_half_ext}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_read_ctrl.sv
// -----------------------------------------------------------------------------
// mem_read_ctrl
// MEM-stage load controller. Issues a read to a synchronous data RAM, waits
// ReadLatency edges, aligns/extends the returned word and presents it as a
// one-cycle LoadValid pulse. The pipeline is stalled while the read is in
// flight. Misaligned requests skip the RAM and complete with MisalignErr.
//   Clock : system clock, posedge
//   Reset : asynchronous, active-low
//   bus   : mem_read_ctrl_if.slave (pipeline controls + RAM read port)
// Parameters: AddrBits (byte address width), DataBits (must be 32),
//             ReadLatency (1..4 RAM edges from address to data).
// -----------------------------------------------------------------------------
module mem_read_ctrl
  import mem_pkg::*;
#(
  parameter int AddrBits    = 32,
  parameter int DataBits    = 32,
  parameter int ReadLatency = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  mem_read_ctrl_if.slave   bus
);

  localparam logic [1:0] LAT_INIT = 2'(ReadLatency - 1);

  logic [1:0]          r_state;
  logic [1:0]          r_count;
  logic [1:0]          r_offset;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic                r_misalign;
  logic [DataBits-1:0] r_load_data;

  logic                w_aligned;
  logic                w_req;
  logic [31:0]         w_extracted;

  assign w_aligned = is_aligned(bus.LoadSize, bus.MemAddr[1:0]);
  // A request is only accepted in IDLE; MemRead seen in DONE is the load
  // that is about to leave the stage.
  assign w_req     = (r_state == ST_IDLE) && bus.MemRead;

  load_align_ext u_align (
    .i_rdata    (bus.mem_rdata),
    .i_offset   (r_offset),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_extracted)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_state     <= ST_IDLE;
      r_count     <= 2'd0;
      r_offset    <= 2'd0;
      r_size      <= SZ_BYTE;
      r_unsigned  <= 1'b0;
      r_misalign  <= 1'b0;
      r_load_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.MemRead) begin
            if (w_aligned) begin
              r_offset   <= bus.MemAddr[1:0];
              r_size     <= bus.LoadSize;
              r_unsigned <= bus.LoadUnsigned;
              r_count    <= LAT_INIT;
              r_state    <= ST_WAIT;
            end else begin
              r_misalign  <= 1'b1;
              r_load_data <= '0;
              r_state     <= ST_DONE;
            end
          end
        end
        ST_WAIT: begin
          if (r_count == 2'd0) begin
            r_load_data <= w_extracted;
            r_state     <= ST_DONE;
          end else begin
            r_count <= r_count - 2'd1;
          end
        end
        ST_DONE: begin
          r_misalign <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Combinational outputs are forced low while Reset is asserted so a
  // pipeline still presenting MemRead during reset issues nothing.
  assign bus.mem_en      = Reset & w_req & w_aligned;
  assign bus.mem_addr    = bus.MemAddr[AddrBits-1:2];
  assign bus.Stall       = Reset & (w_req | (r_state == ST_WAIT));
  assign bus.LoadValid   = (r_state == ST_DONE);
  assign bus.MisalignErr = (r_state == ST_DONE) & r_misalign;
  assign bus.LoadData    = r_load_data;

endmodule

// File: doc/mem_read_ctrl.md
Name: mem_read_ctrl

Overview:
MEM-stage load controller that consumes the registered MemRead/address/size controls leaving the EX/MEM pipeline register, issues the read to the synchronous data RAM, and waits the RAM's read latency. It aligns and sign/zero-extends the returned word into LoadData for the MEM/WB register. It stalls the pipeline while the read is in flight and flags misaligned accesses without touching memory.

Parameters:
AddrBits, 32, width of the byte address from EX/MEM.
DataBits, 32, RAM word width; fixed at 32 for byte/half extraction.
ReadLatency, 1, RAM clock edges from address capture to valid mem_rdata; legal 1..4.

Ports:
Clock  input  1  system clock; all state updates on posedge.
Reset  input  1  asynchronous, active-low reset.
MemRead  input  1  load request from the EX/MEM register; level, held until Stall drops.
MemAddr  input  AddrBits  byte address of the load.
LoadSize  input  2  00 byte, 01 halfword, 10/11 word.
LoadUnsigned  input  1  1 zero-extends, 0 sign-extends byte/half.
mem_en  output  1  RAM read enable.
mem_addr  output  AddrBits-2  RAM word address, MemAddr[AddrBits-1:2].
mem_rdata  input  DataBits  RAM read data.
Stall  output  1  freeze the PC, IF/ID, ID/EX and EX/MEM registers.
LoadData  output  DataBits  aligned, extended load result.
LoadValid  output  1  one-cycle pulse; LoadData is valid this cycle.
MisalignErr  output  1  one-cycle pulse alongside LoadValid on a misaligned request.

Behaviour:
- FSM states: IDLE, WAIT, DONE. Registers: state, latency counter (2 bits), byte offset (2), size (2), unsigned (1), misalign flag, LoadData.
- Reset (Reset=0, async): state IDLE, counter 0, LoadData 0, LoadValid 0, MisalignErr 0, mem_en 0, Stall 0. A reset mid-read abandons the read; late mem_rdata is ignored.
- IDLE, MemRead=0: all outputs 0 except LoadData, which holds its last value.
- IDLE, MemRead=1, aligned: mem_en=1 and mem_addr=MemAddr[AddrBits-1:2] combinationally in this cycle. Stall=1. At the edge, latch offset/size/unsigned, counter=ReadLatency-1, go to WAIT.
- Alignment rule: a halfword requires MemAddr[0]=0; a word requires MemAddr[1:0]=00; a byte is always aligned.
- IDLE, MemRead=1, misaligned: mem_en=0, Stall=1. At the edge, set the misalign flag, LoadData=0, go to DONE.
- WAIT: Stall=1, mem_en=0. If counter=0, at the edge capture extract(mem_rdata) into LoadData and go to DONE; else decrement the counter.
- DONE: Stall=0, LoadValid=1, MisalignErr=misalign flag. At the edge go to IDLE and clear the flag. MemRead is ignored in DONE; the pipeline advances at this edge, so MemRead in the next IDLE cycle is a new load.
- Latency: request seen in cycle 0; LoadValid is high in cycle ReadLatency+1; Stall is high in cycles 0..ReadLatency. A misaligned request gives LoadValid in cycle 1.
- Extract, byte: lane = mem_rdata[8*off+7 : 8*off] (little-endian); bits 31..8 are zeros if unsigned, else copies of the lane's bit 7.
- Extract, half: lane = mem_rdata[16*off[1]+15 : 16*off[1]]; extended to 32 bits the same way from bit 15.
- Extract, word: mem_rdata unchanged; LoadUnsigned is ignored.
- mem_addr is driven from MemAddr in every state. Only mem_en qualifies the access.

Decomposition:
- Shared package mem_pkg: LoadSize encodings (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10), FSM state encoding (IDLE=0, WAIT=1, DONE=2), and a function is_aligned(size, addr[1:0]).
- One sub-module, load_align_ext: purely combinational (rdata, offset, size, unsigned) -> aligned result. It is tested standalone and instantiated once.

Test Plan:
- ReadLatency=1; MemRead=1, MemAddr=0x104, LoadSize=10, RAM word at 0x41 = 0xDEADBEEF -> mem_en=1 with mem_addr=0x41 in cycle 0; Stall high in cycles 0–1; cycle 2 LoadValid=1, LoadData=0xDEADBEEF.
- Byte sign/zero: addr 0x107, word 0x80FF1234, signed -> LoadData=0xFFFFFF80; same with LoadUnsigned=1 -> 0x00000080. Half at addr 0x106, signed -> 0xFFFF80FF.
- Misaligned half at 0x103 -> mem_en stays 0; Stall high in cycle 0 only; cycle 1 LoadValid=1, MisalignErr=1, LoadData=0.
- ReadLatency=3, word load -> Stall high in cycles 0–3; LoadValid in cycle 4; LoadData equals mem_rdata presented at the third edge after the request.
- Back-to-back: MemRead held high across two loads (0x100, then 0x104 after the DONE edge) -> two distinct LoadValid pulses with a one-cycle IDLE re-issue between them; no double read of 0x100.
- Reset driven low while in WAIT -> immediately Stall=0, LoadValid=0, LoadData=0, state IDLE; after Reset goes high with MemRead=0, mem_en stays 0.
